// File: rtl/framing_512_ctrl_pkg.sv
// Shared types and geometry helpers for the frame sequencer.
// HOP and index width are derived from frame length and overlap mode.
package framing_512_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIST = 2'd1,
    ST_NEW  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int hop_f(input int frame_len, input int overlap_en);
    return (overlap_en != 0) ? frame_len / 2 : frame_len;
  endfunction

  function automatic int idx_w_f(input int frame_len, input int overlap_en);
    return $clog2(hop_f(frame_len, overlap_en));
  endfunction

endpackage

// File: rtl/framing_out_skid.sv
// Two-entry valid/ready register FIFO carrying {sof, eof, data}.
// Caller guarantees no push when full; pop is ignored when empty.
module framing_out_skid #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         pop_ok;

  assign pop_ok  = pop_i & (cnt_q != 2'd0);
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_ok})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/framing_512_ctrl.sv
// Frame sequencer: drains a show-ahead FIFO into fixed-length frames with
// SOF/EOF, optionally replaying the previous frame's second half (50% overlap).
module framing_512_ctrl
  import framing_512_ctrl_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 512,
  parameter int OVERLAP_EN = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              flush,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eof,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              busy
);

  localparam int               HOP      = hop_f(FRAME_LEN, OVERLAP_EN);
  localparam int               IDX_W    = idx_w_f(FRAME_LEN, OVERLAP_EN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HOP - 1);
  localparam bit               OVL      = (OVERLAP_EN != 0);
  localparam int               SKID_W   = DATA_W + 2;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               bank_sel_q, bank_sel_d;
  logic               hist_valid_q, hist_valid_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               issue_hist, issue_new, sof_tag, eof_tag, can_issue;
  logic               pipe_vld_q, pipe_sof_q, pipe_eof_q, pipe_hist_q, pipe_zero_q;
  logic [DATA_W-1:0]  new_q, ram_rd_q, pipe_data;
  logic [DATA_W-1:0]  hist_mem [2*HOP];

  logic               skid_valid, skid_pop;
  logic [SKID_W-1:0]  skid_out;
  logic [1:0]         skid_cnt, occ;

  // Occupancy counts this cycle's pop so a steady stream never bubbles.
  assign skid_pop  = skid_valid & m_ready;
  assign occ       = skid_cnt - {1'b0, skid_pop} + {1'b0, pipe_vld_q};
  assign can_issue = !rst && (occ < 2'd2);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bank_sel_d   = bank_sel_q;
    hist_valid_d = hist_valid_q;
    frame_cnt_d  = frame_cnt_q;
    issue_hist   = 1'b0;
    issue_new    = 1'b0;
    sof_tag      = 1'b0;
    eof_tag      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) hist_valid_d = 1'b0;
        if (enable) state_d = OVL ? ST_HIST : ST_NEW;
      end
      ST_HIST: begin
        if (can_issue) begin
          issue_hist = 1'b1;
          sof_tag    = (idx_q == '0);
          idx_d      = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = ST_NEW;
        end
      end
      ST_NEW: begin
        if (can_issue && fifo_rd_vld) begin
          issue_new = 1'b1;
          sof_tag   = !OVL && (idx_q == '0);
          eof_tag   = (idx_q == IDX_LAST);
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bank_sel_d   = ~bank_sel_q;
        hist_valid_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + CNT_W'(1);
        idx_d        = '0;
        if (enable) state_d = OVL ? ST_HIST : ST_NEW;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_rd_en = issue_new;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      bank_sel_q   <= 1'b0;
      hist_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
      pipe_vld_q   <= 1'b0;
      pipe_sof_q   <= 1'b0;
      pipe_eof_q   <= 1'b0;
      pipe_hist_q  <= 1'b0;
      pipe_zero_q  <= 1'b0;
      new_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bank_sel_q   <= bank_sel_d;
      hist_valid_q <= hist_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      pipe_vld_q   <= issue_hist | issue_new;
      pipe_sof_q   <= sof_tag;
      pipe_eof_q   <= eof_tag;
      pipe_hist_q  <= issue_hist;
      pipe_zero_q  <= issue_hist & ~hist_valid_q;
      if (issue_new) new_q <= fifo_rd_data;
    end
  end

  // History RAM: write the live bank, read the other one; contents survive reset.
  always_ff @(posedge clk) begin
    if (issue_new && OVL) hist_mem[{bank_sel_q, idx_q}] <= fifo_rd_data;
    if (issue_hist) ram_rd_q <= hist_mem[{~bank_sel_q, idx_q}];
  end

  assign pipe_data = pipe_zero_q ? '0 : (pipe_hist_q ? ram_rd_q : new_q);

  framing_out_skid #(.W(SKID_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pipe_vld_q),
    .push_data_i ({pipe_sof_q, pipe_eof_q, pipe_data}),
    .pop_i       (skid_pop),
    .valid_o     (skid_valid),
    .data_o      (skid_out),
    .cnt_o       (skid_cnt)
  );

  assign m_valid   = skid_valid;
  assign m_data    = skid_out[DATA_W-1:0];
  assign m_sof     = skid_valid & skid_out[SKID_W-1];
  assign m_eof     = skid_valid & skid_out[SKID_W-2];
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != ST_IDLE) || (skid_cnt != 2'd0) || pipe_vld_q;

endmodule

// File: tb/tb_framing_512_ctrl.sv
// Directed bench: overlap instance (A) and no-overlap instance (B), both FRAME_LEN=8.
module tb_framing_512_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_enable, a_flush, a_rd_vld, a_rd_en, a_m_valid, a_m_ready, a_sof, a_eof, a_busy;
  logic [15:0] a_rd_data, a_m_data, a_cnt;
  logic        b_enable, b_flush, b_rd_vld, b_rd_en, b_m_valid, b_m_ready, b_sof, b_eof, b_busy;
  logic [15:0] b_rd_data, b_m_data, b_cnt;

  framing_512_ctrl #(.DATA_W(16), .FRAME_LEN(8), .OVERLAP_EN(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .enable(a_enable), .flush(a_flush),
    .fifo_rd_data(a_rd_data), .fifo_rd_vld(a_rd_vld), .fifo_rd_en(a_rd_en),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
    .m_sof(a_sof), .m_eof(a_eof), .frame_cnt(a_cnt), .busy(a_busy));

  framing_512_ctrl #(.DATA_W(16), .FRAME_LEN(8), .OVERLAP_EN(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .enable(b_enable), .flush(b_flush),
    .fifo_rd_data(b_rd_data), .fifo_rd_vld(b_rd_vld), .fifo_rd_en(b_rd_en),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_sof(b_sof), .m_eof(b_eof), .frame_cnt(b_cnt), .busy(b_busy));

  int          n_checks = 0;
  int          n_fail   = 0;
  int          src_a[$];
  int          src_b[$];
  logic [17:0] out_a[$];
  logic [17:0] out_b[$];
  int          pops_b = 0;
  bit          ready_toggle = 0;
  bit          gap_en = 0;
  int          exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    a_rd_vld  = (src_a.size() > 0) && !(gap_en && ($urandom_range(0, 2) == 0));
    a_rd_data = (src_a.size() > 0) ? 16'(src_a[0]) : 16'd0;
    b_rd_vld  = (src_b.size() > 0);
    b_rd_data = (src_b.size() > 0) ? 16'(src_b[0]) : 16'd0;
  endtask

  // One clock: observe the cycle at negedge, then update FIFO models after the edge.
  task automatic step();
    bit pa, pb;
    @(negedge clk);
    pa = a_rd_en && a_rd_vld;
    pb = b_rd_en && b_rd_vld;
    if (a_m_valid && a_m_ready) out_a.push_back({a_sof, a_eof, a_m_data});
    if (b_m_valid && b_m_ready) out_b.push_back({b_sof, b_eof, b_m_data});
    if (b_rd_en) pops_b++;
    @(posedge clk);
    #1;
    if (!rst && pa && src_a.size() > 0) void'(src_a.pop_front());
    if (!rst && pb && src_b.size() > 0) void'(src_b.pop_front());
    a_m_ready = ready_toggle ? ~a_m_ready : 1'b1;
    drive_fifo();
  endtask

  task automatic load_a(input int first, input int last);
    for (int v = first; v <= last; v++) src_a.push_back(v);
    drive_fifo();
  endtask

  task automatic wait_cnt_a(input string tag, input int target);
    int n = 0;
    while (a_cnt != 16'(target) && n < 400) begin step(); n++; end
    check(tag, 32'(a_cnt), 32'(target));
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (a_busy && n < 400) begin step(); n++; end
    check(tag, 32'(a_busy), 32'd0);
  endtask

  task automatic pulse_enable_a();
    a_enable = 1'b1;
    step();
    a_enable = 1'b0;
  endtask

  task automatic cmp_stream(input string tag, input logic [17:0] got[$], input int exp[$]);
    int n;
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(got[i]),
            32'({(i % 8) == 0, (i % 8) == 7, 16'(exp[i])}));
  endtask

  initial begin
    rst = 1'b1;
    a_enable = 0; a_flush = 0; a_m_ready = 1;
    b_enable = 0; b_flush = 0; b_m_ready = 1;
    drive_fifo();
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_m_valid", 32'(a_m_valid), 32'd0);
    check("rst_m_data", 32'(a_m_data), 32'd0);
    check("rst_sof_eof", 32'({a_sof, a_eof}), 32'd0);
    check("rst_cnt", 32'(a_cnt), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_rd_en", 32'(a_rd_en), 32'd0);

    // No-overlap: two frames straight from the FIFO.
    for (int v = 1; v <= 16; v++) src_b.push_back(v);
    drive_fifo();
    b_enable = 1'b1;
    begin
      int n = 0;
      while (b_cnt != 16'd1 && n < 400) begin step(); n++; end
      check("b_cnt1", 32'(b_cnt), 32'd1);
    end
    b_enable = 1'b0;
    begin
      int n = 0;
      while (b_busy && n < 400) begin step(); n++; end
      check("b_idle", 32'(b_busy), 32'd0);
    end
    exp_q = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    cmp_stream("b_frames", out_b, exp_q);
    check("b_pops", 32'(pops_b), 32'd16);
    check("b_cnt2", 32'(b_cnt), 32'd2);

    // Overlap, unstalled: three frames from 1..12.
    out_a.delete();
    load_a(1, 12);
    a_enable = 1'b1;
    wait_cnt_a("a1_cnt2", 2);
    a_enable = 1'b0;
    wait_idle_a("a1_idle");
    exp_q = {0, 0, 0, 0, 1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 7, 8, 5, 6, 7, 8, 9, 10, 11, 12};
    cmp_stream("a1", out_a, exp_q);
    check("a1_cnt3", 32'(a_cnt), 32'd3);

    // Same traffic with m_ready toggling and random FIFO gaps, after a reset.
    rst = 1'b1; step(); rst = 1'b0;
    out_a.delete();
    ready_toggle = 1; gap_en = 1;
    load_a(1, 12);
    a_enable = 1'b1;
    wait_cnt_a("a2_cnt2", 2);
    a_enable = 1'b0;
    wait_idle_a("a2_idle");
    cmp_stream("a2", out_a, exp_q);
    ready_toggle = 0; gap_en = 0; a_m_ready = 1'b1;

    // Enable dropped during frame1; frame1 finishes, then re-enable.
    rst = 1'b1; step(); rst = 1'b0;
    out_a.delete();
    load_a(1, 8);
    a_enable = 1'b1;
    wait_cnt_a("a3_cnt1", 1);
    repeat (3) step();
    a_enable = 1'b0;
    wait_idle_a("a3_idle");
    exp_q = {0, 0, 0, 0, 1, 2, 3, 4, 1, 2, 3, 4, 5, 6, 7, 8};
    cmp_stream("a3", out_a, exp_q);
    check("a3_cnt", 32'(a_cnt), 32'd2);
    out_a.delete();
    load_a(9, 12);
    pulse_enable_a();
    wait_idle_a("a3r_idle");
    exp_q = {5, 6, 7, 8, 9, 10, 11, 12};
    cmp_stream("a3r", out_a, exp_q);
    check("a3r_cnt", 32'(a_cnt), 32'd3);

    // Flush in IDLE zeroes the next history half.
    a_flush = 1'b1; step(); a_flush = 1'b0;
    out_a.delete();
    load_a(13, 16);
    pulse_enable_a();
    wait_idle_a("a4_idle");
    exp_q = {0, 0, 0, 0, 13, 14, 15, 16};
    cmp_stream("a4", out_a, exp_q);
    check("a4_cnt", 32'(a_cnt), 32'd4);

    // Reset while NEW is stalled on an empty FIFO.
    load_a(21, 22);
    pulse_enable_a();
    repeat (15) step();
    check("a5_busy_mid", 32'(a_busy), 32'd1);
    rst = 1'b1; step();
    check("a5_rst_valid", 32'(a_m_valid), 32'd0);
    check("a5_rst_cnt", 32'(a_cnt), 32'd0);
    check("a5_rst_busy", 32'(a_busy), 32'd0);
    rst = 1'b0;
    src_a.delete();
    out_a.delete();
    load_a(31, 34);
    pulse_enable_a();
    wait_idle_a("a5_idle");
    exp_q = {0, 0, 0, 0, 31, 32, 33, 34};
    cmp_stream("a5", out_a, exp_q);
    check("a5_cnt", 32'(a_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
